reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register latency scoreboard for an in-order pipeline.
// Each architectural register r = 1..31 has a down-counter holding the number
// of cycles until its pending result becomes forwardable. The ID stage stalls
// while any source it actually reads has a nonzero counter.
// Optional feature: define SCOREBOARD_STATS_EN to count stalled issue cycles
// on stall_cycles; otherwise stall_cycles is tied to zero.
module reg_scoreboard #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [4:0]       issue_waddr,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic             stall,
    output logic             issue_ack,
    output logic [5:0]       pending_cnt,
    output logic [15:0]      stall_cycles
);

    localparam logic [LAT_W-1:0] CNT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};

    // Counter decremented by one, saturating at zero.
    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
        logic [LAT_W-1:0] res;
        if (v != CNT_ZERO) begin
            res = v - CNT_ONE;
        end else begin
            res = CNT_ZERO;
        end
        return res;
    endfunction

    // Larger of two counter values; a WAW reissue never shortens a pending wait.
    function automatic logic [LAT_W-1:0] cnt_max(input logic [LAT_W-1:0] a,
                                                 input logic [LAT_W-1:0] b);
        logic [LAT_W-1:0] res;
        if (a > b) begin
            res = a;
        end else begin
            res = b;
        end
        return res;
    endfunction

    // Entry 0 exists only to keep indexing uniform; it is held at zero.
    logic [LAT_W-1:0] cnt_q [32];
    logic [LAT_W-1:0] cnt_d [32];
    logic [5:0]       pend_q;
    logic [5:0]       pend_d;
    logic             rs_busy_s;
    logic             rt_busy_s;

    // Hazard detection from pre-edge counters, so an instruction never waits on its own destination.
    always_comb begin
        rs_busy_s = rs_used && (rs_addr != 5'd0) && (cnt_q[rs_addr] != CNT_ZERO);
        rt_busy_s = rt_used && (rt_addr != 5'd0) && (cnt_q[rt_addr] != CNT_ZERO);
        stall     = rs_busy_s || rt_busy_s;
        issue_ack = issue_valid && !stall;
    end

    // Next-state counters: decrement everywhere, load max(lat, cnt-1) on an accepted write.
    always_comb begin
        pend_d = 6'd0;
        for (int r = 0; r < 32; r++) begin
            if (r == 0) begin
                cnt_d[r] = CNT_ZERO;
            end else if (issue_ack && issue_we && (issue_waddr == 5'(r))) begin
                cnt_d[r] = cnt_max(issue_lat, sat_dec(cnt_q[r]));
            end else begin
                cnt_d[r] = sat_dec(cnt_q[r]);
            end
            pend_d = pend_d + {5'd0, (cnt_d[r] != CNT_ZERO)};
        end
    end

    // Counter and pending-count registers; reset overrides any simultaneous issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            pend_q <= 6'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pend_q <= pend_d;
        end
    end

    assign pending_cnt = pend_q;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;

    // Saturating count of cycles where an instruction was presented but stalled.
    always_comb begin
        if (issue_valid && stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall statistics register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 16'h0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule
